stock_price_update_ctrl: RTL

//  Read-modify-write controller directly upstream of the 512x49 stock price table.
//  - Accepts parsed market-data updates (index, price, qty) and merges them into the table.
//  - Raises a trade trigger when a tracked stock's price drops by at least DELTA_THRESH.
//  - Sole owner of the table's single port; no other agent drives the table.
//  - Table entry format [48:0] = {valid[48], price[47:16], qty[15:0]}.

---
 rtl/stock_price_update_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stock_price_update_ctrl.sv
// Read-modify-write controller in front of the 512x49 stock price table; fires a trade trigger on large price drops.
// Optional statistics counters are enabled by defining STOCK_PRICE_STATS_EN.
module stock_price_update_ctrl #(
  parameter logic [31:0] DELTA_THRESH = 32'd100,
  parameter bit          INIT_CLEAR   = 1'b1
) (
  input  logic        axis_aclk,
  input  logic        axis_resetn,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [8:0]  upd_index,
  input  logic [31:0] upd_price,
  input  logic [15:0] upd_qty,
  output logic [8:0]  ram_addr,
  output logic [48:0] ram_din,
  output logic        ram_we,
  input  logic [48:0] ram_dout,
  output logic        trig_valid,
  input  logic        trig_ready,
  output logic [8:0]  trig_index,
  output logic [31:0] trig_old_price,
  output logic [31:0] trig_new_price
`ifdef STOCK_PRICE_STATS_EN
  ,
  output logic [31:0] stat_upd_cnt,
  output logic [31:0] stat_trig_cnt,
  output logic [15:0] stat_sat_cnt
`endif
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_WR, S_EMIT} state_t;

  typedef struct packed {
    logic [8:0]  idx;
    logic [31:0] price;
    logic [15:0] qty;
  } upd_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] price;
    logic [15:0] qty;
  } entry_t;

  localparam state_t RST_STATE = INIT_CLEAR ? S_INIT : S_IDLE;

  state_t      state_q, state_d;
  upd_req_t    req_q, req_d;
  logic        fire_q, fire_d;
  logic [31:0] old_price_q, old_price_d;
  logic        upd_ready_q, upd_ready_d;
  logic [8:0]  ram_addr_q, ram_addr_d;
  logic [48:0] ram_din_q, ram_din_d;
  logic        ram_we_q, ram_we_d;
  logic        trig_valid_q, trig_valid_d;

  entry_t      old;
  logic [16:0] qty_sum;
  logic [15:0] new_qty;
  logic        sat;
  logic        accept;
  logic        trig_hs;

  assign old     = entry_t'(ram_dout);
  assign qty_sum = {1'b0, old.qty} + {1'b0, req_q.qty};
  assign sat     = old.valid && qty_sum[16];
  assign new_qty = !old.valid ? req_q.qty : (qty_sum[16] ? 16'hFFFF : qty_sum[15:0]);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    fire_d       = fire_q;
    old_price_d  = old_price_q;
    upd_ready_d  = upd_ready_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = ram_we_q;
    trig_valid_d = trig_valid_q;
    accept       = 1'b0;
    trig_hs      = 1'b0;
    case (state_q)
      // First cycle after reset only arms the sweep; the write pulses run addr 0..511.
      S_INIT: begin
        if (!ram_we_q) begin
          ram_we_d   = 1'b1;
          ram_addr_d = 9'd0;
          ram_din_d  = '0;
        end else if (ram_addr_q == 9'd511) begin
          ram_we_d    = 1'b0;
          upd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ram_addr_d = ram_addr_q + 9'd1;
        end
      end
      S_IDLE: begin
        upd_ready_d = 1'b1;
        if (upd_valid && upd_ready_q) begin
          accept      = 1'b1;
          req_d       = '{idx: upd_index, price: upd_price, qty: upd_qty};
          upd_ready_d = 1'b0;
          ram_addr_d  = upd_index;
          state_d     = S_RD;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        fire_d      = old.valid && (old.price > req_q.price) &&
                      ((old.price - req_q.price) >= DELTA_THRESH);
        old_price_d = old.price;
        ram_we_d    = 1'b1;
        ram_din_d   = {1'b1, req_q.price, new_qty};
        state_d     = S_WR;
      end
      S_WR: begin
        ram_we_d = 1'b0;
        if (fire_q) begin
          trig_valid_d = 1'b1;
          state_d      = S_EMIT;
        end else begin
          upd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_EMIT: begin
        if (trig_ready) begin
          trig_hs      = 1'b1;
          trig_valid_d = 1'b0;
          upd_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= RST_STATE;
      req_q        <= '0;
      fire_q       <= 1'b0;
      old_price_q  <= '0;
      upd_ready_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      trig_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fire_q       <= fire_d;
      old_price_q  <= old_price_d;
      upd_ready_q  <= upd_ready_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      trig_valid_q <= trig_valid_d;
    end
  end

  assign upd_ready      = upd_ready_q;
  assign ram_addr       = ram_addr_q;
  assign ram_din        = ram_din_q;
  assign ram_we         = ram_we_q;
  assign trig_valid     = trig_valid_q;
  // Request fields stay latched until the next accept, which cannot happen before the trigger handshake.
  assign trig_index     = req_q.idx;
  assign trig_old_price = old_price_q;
  assign trig_new_price = req_q.price;

`ifdef STOCK_PRICE_STATS_EN
  logic [31:0] upd_cnt_q, trig_cnt_q;
  logic [15:0] sat_cnt_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      upd_cnt_q  <= '0;
      trig_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      if (accept)                    upd_cnt_q  <= upd_cnt_q + 32'd1;
      if (trig_hs)                   trig_cnt_q <= trig_cnt_q + 32'd1;
      if (state_q == S_CMP && sat)   sat_cnt_q  <= sat_cnt_q + 16'd1;
    end
  end

  assign stat_upd_cnt  = upd_cnt_q;
  assign stat_trig_cnt = trig_cnt_q;
  assign stat_sat_cnt  = sat_cnt_q;
`else
  logic unused_ok;
  assign unused_ok = accept ^ trig_hs ^ sat;
`endif

endmodule
